// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and constants for the Dino Run blocks
//
// Holds the jump FSM state type and the geometry and controller-bit
// constants shared by the jump controller and the renderer.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    DEAD   = 2'd3
  } dino_jump_state_t;

  localparam int DINO_GROUND_Y   = 348;
  localparam int DINO_W          = 32;
  localparam int DINO_H          = 32;
  localparam int CTRL_JUMP_BIT   = 5;
  localparam int CTRL_REPLAY_BIT = 4;

endpackage

// File: rtl/dino_tick_div.sv
// rtl/dino_tick_div.sv - physics tick divider
//
// Counts clk cycles 0..PHYS_DIV-1 and flags the last one as a tick.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   hold  in  forces the counter to 0 (no ticks while held)
//   tick  out high in the cycle the counter sits at PHYS_DIV-1
module dino_tick_div #(
  parameter int PHYS_DIV = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(PHYS_DIV);
  localparam logic [CW-1:0] LAST = CW'(PHYS_DIV - 1);

  logic [CW-1:0] tcnt_q, tcnt_d;

  assign tick = (tcnt_q == LAST);

  always_comb begin
    tcnt_d = tcnt_q + CW'(1);
    if (hold || tick) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

endmodule

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - dino jump physics FSM with frame-synchronous output
//
// Turns a jump-button press into a gravity trajectory and publishes the
// sprite y to the renderer only at frame start.
// Ports:
//   clk               in  system clock
//   reset             in  synchronous, active-high
//   controller_report in  registered controller byte (JUMP_BIT = jump button)
//   game_over         in  level from the collision block; freezes the dino
//   frame_start       in  one-cycle pulse at the start of vertical blanking
//   dino_y            out sprite top y, updated on frame_start
//   airborne          out state != GROUND, updated on frame_start
//   landed            out one-cycle pulse after the landing tick
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_Y = DINO_GROUND_Y,
  parameter int MIN_Y    = 40,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int PHYS_DIV = 500_000,
  parameter int JUMP_BIT = CTRL_JUMP_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  controller_report,
  input  logic        game_over,
  input  logic        frame_start,
  output logic [10:0] dino_y,
  output logic        airborne,
  output logic        landed
);

  localparam logic [10:0] GY = 11'(GROUND_Y);
  localparam logic [10:0] MY = 11'(MIN_Y);
  localparam logic [5:0]  V0 = 6'(JUMP_V0);
  localparam logic [5:0]  GR = 6'(GRAVITY);

  dino_jump_state_t state_q, state_d;
  logic [10:0] y_int_q, y_int_d;
  logic [5:0]  vel_q, vel_d;
  logic        pending_q, pending_d;
  logic        landed_q, landed_d;
  logic        btn_q;
  logic [10:0] dino_y_q;
  logic        airborne_q;

  logic        btn, press, tick, hold;
  logic [11:0] rise_y, fall_y;
  logic        rise_clamp;
  logic [6:0]  vel_inc;
  logic        unused_report;

  assign unused_report = ^controller_report;
  assign btn   = controller_report[JUMP_BIT];
  assign press = btn & ~btn_q;

  // The counter is also cleared on the cycle game_over arrives, so it
  // already reads 0 in the first DEAD cycle and restarts from 0 on exit.
  assign hold = game_over | (state_q == DEAD);

  dino_tick_div #(.PHYS_DIV(PHYS_DIV)) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .tick (tick)
  );

  // 12-bit arithmetic: the clamp test avoids y - vel wrapping below 0.
  assign rise_y     = {1'b0, y_int_q} - {6'b0, vel_q};
  assign rise_clamp = {1'b0, y_int_q} < ({6'b0, vel_q} + {1'b0, MY});
  assign fall_y     = {1'b0, y_int_q} + {6'b0, vel_q};
  assign vel_inc    = {1'b0, vel_q} + {1'b0, GR};

  always_comb begin
    state_d   = state_q;
    y_int_d   = y_int_q;
    vel_d     = vel_q;
    pending_d = pending_q;
    landed_d  = 1'b0;
    if (game_over) begin
      // game_over beats any same-cycle tick: no physics update.
      state_d   = DEAD;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        GROUND: begin
          y_int_d = GY;
          vel_d   = '0;
          if (tick && (pending_q || press)) begin
            vel_d     = V0;
            pending_d = 1'b0;
            state_d   = RISE;
          end else if (press) begin
            pending_d = 1'b1;
          end
        end
        RISE: begin
          if (tick) begin
            y_int_d = rise_clamp ? MY : rise_y[10:0];
            if (vel_q <= GR) begin
              vel_d   = '0;
              state_d = FALL;
            end else begin
              vel_d = vel_q - GR;
            end
          end
        end
        FALL: begin
          if (tick) begin
            if (fall_y >= {1'b0, GY}) begin
              y_int_d  = GY;
              vel_d    = '0;
              state_d  = GROUND;
              landed_d = 1'b1;
            end else begin
              y_int_d = fall_y[10:0];
              vel_d   = (vel_inc > {1'b0, V0}) ? V0 : vel_inc[5:0];
            end
          end
        end
        DEAD: begin
          pending_d = 1'b0;
          y_int_d   = GY;
          vel_d     = '0;
          state_d   = GROUND;
        end
        default: state_d = GROUND;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GROUND;
      y_int_q    <= GY;
      vel_q      <= '0;
      pending_q  <= 1'b0;
      landed_q   <= 1'b0;
      btn_q      <= 1'b0;
      dino_y_q   <= GY;
      airborne_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_int_q   <= y_int_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
      landed_q  <= landed_d;
      btn_q     <= btn;
      // Samples the pre-update state, so the sprite never tears mid-frame.
      if (frame_start) begin
        dino_y_q   <= y_int_q;
        airborne_q <= (state_q != GROUND);
      end
    end
  end

  assign dino_y   = dino_y_q;
  assign airborne = airborne_q;
  assign landed   = landed_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb/tb_dino_jump_ctrl.sv - self-checking bench for dino_jump_ctrl
module tb_dino_jump_ctrl;
  import dino_pkg::*;

  localparam int PD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn = 1'b0;
  logic        game_over = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  report = 8'h00;
  logic [10:0] dy0, dy1;
  logic        air0, air1, ld0, ld1;

  always #5 clk = ~clk;

  dino_jump_ctrl #(.PHYS_DIV(PD)) dut (
    .clk(clk), .reset(reset), .controller_report(report), .game_over(game_over),
    .frame_start(frame_start), .dino_y(dy0), .airborne(air0), .landed(ld0)
  );

  dino_jump_ctrl #(.PHYS_DIV(PD), .MIN_Y(300)) dut_c (
    .clk(clk), .reset(reset), .controller_report(report), .game_over(game_over),
    .frame_start(frame_start), .dino_y(dy1), .airborne(air1), .landed(ld1)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference: a precomputed trajectory per config, indexed by ticks since launch.
  int traj[2][64];
  bit rise_t[2][64];
  int land_k[2];
  bit m_dead[2], m_pend[2], m_prev[2], m_land[2], m_air[2];
  int m_k[2], m_nt[2], m_tc[2], m_dy[2];

  function automatic void build_traj(input int c, input int miny);
    int y, v;
    bit rising;
    y = 348; v = 12; rising = 1'b1;
    traj[c][1] = 348; rise_t[c][1] = 1'b1; land_k[c] = 0;
    for (int k = 2; k < 64; k++) begin
      if (rising) begin
        y = (y - v < miny) ? miny : y - v;
        if (v <= 1) begin v = 0; rising = 1'b0; end else v = v - 1;
      end else begin
        if (y + v >= 348) begin
          land_k[c] = k; traj[c][k] = 348; rise_t[c][k] = 1'b0;
          break;
        end
        y = y + v;
        v = (v + 1 > 12) ? 12 : v + 1;
      end
      traj[c][k] = y; rise_t[c][k] = rising;
    end
  endfunction

  function automatic int model_y(input int c);
    return (m_k[c] == 0) ? 348 : traj[c][m_k[c]];
  endfunction

  function automatic int model_st(input int c);
    if (m_dead[c]) return int'(DEAD);
    if (m_k[c] == 0) return int'(GROUND);
    return rise_t[c][m_k[c]] ? int'(RISE) : int'(FALL);
  endfunction

  function automatic void model_step(input int c);
    bit press, tick, was_dead;
    if (reset) begin
      m_dead[c] = 0; m_pend[c] = 0; m_prev[c] = 0; m_k[c] = 0; m_nt[c] = 0;
      m_tc[c] = 0; m_dy[c] = 348; m_air[c] = 0; m_land[c] = 0;
      return;
    end
    press = btn && !m_prev[c];
    m_prev[c] = btn;
    tick = (m_tc[c] == PD - 1);
    was_dead = m_dead[c];
    m_land[c] = 0;
    if (frame_start) begin
      m_dy[c] = model_y(c);
      m_air[c] = m_dead[c] || (m_k[c] != 0);
    end
    m_tc[c] = (game_over || was_dead || tick) ? 0 : m_tc[c] + 1;
    if (game_over) begin
      m_dead[c] = 1; m_pend[c] = 0;
    end else if (m_dead[c]) begin
      m_dead[c] = 0; m_k[c] = 0; m_pend[c] = 0;
    end else if (m_k[c] == 0) begin
      if (tick && (m_pend[c] || press)) begin
        m_k[c] = 1; m_nt[c] = 1; m_pend[c] = 0;
      end else if (press) begin
        m_pend[c] = 1;
      end
    end else if (tick) begin
      m_k[c] = m_k[c] + 1;
      m_nt[c] = m_k[c];
      if (m_k[c] == land_k[c]) begin
        m_k[c] = 0; m_land[c] = 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  int   land_cnt0 = 0;
  int   dy_prev0 = 0;
  bit   have_prev = 0;

  function automatic void check_all();
    chk("dino_y", int'(dy0), m_dy[0]);
    chk("airborne", int'(air0), int'(m_air[0]));
    chk("landed", int'(ld0), int'(m_land[0]));
    chk("y_int", int'(dut.y_int_q), model_y(0));
    chk("state", int'(dut.state_q), model_st(0));
    chk("tcnt", int'(dut.u_tick_div.tcnt_q), m_tc[0]);
    chk("c_dino_y", int'(dy1), m_dy[1]);
    chk("c_airborne", int'(air1), int'(m_air[1]));
    chk("c_landed", int'(ld1), int'(m_land[1]));
    chk("c_y_int", int'(dut_c.y_int_q), model_y(1));
    chk("c_state", int'(dut_c.state_q), model_st(1));
    if (have_prev && !frame_start && !reset) chk("dy_hold", int'(dy0), dy_prev0);
    dy_prev0 = int'(dy0);
    have_prev = 1;
    if (ld0) land_cnt0++;
  endfunction

  task automatic step(input logic b, input logic g, input logic r);
    logic [7:0] rep;
    @(negedge clk);
    check_all();
    rep = 8'($urandom);
    rep[5] = b;
    report = rep;
    btn = b;
    game_over = g;
    reset = r;
    frame_start = (cyc % 16 == 15);
    cyc++;
  endtask

  task automatic wait_nt(input int c, input int n);
    int i;
    i = 0;
    while (m_nt[c] != n && i < 600) begin
      step(1'b0, 1'b0, 1'b0);
      i++;
    end
    if (i >= 600) begin
      n_checks++; n_err++;
      $display("FAIL wait_tick: tick %0d of cfg %0d not reached, got %0d", n, c, m_nt[c]);
    end
  endtask

  task automatic wait_tc(input int v);
    int i;
    i = 0;
    while (m_tc[0] != v && i < 20) begin
      step(1'b0, 1'b0, 1'b0);
      i++;
    end
  endtask

  typedef struct {
    int cfg;
    int nt;
    int exp_y;
    dino_jump_state_t exp_st;
  } chkpt_t;

  chkpt_t tbl[9];

  initial begin
    int i;
    logic rb, rg, rr;
    tbl[0] = '{0, 1, 348, RISE};
    tbl[1] = '{0, 2, 336, RISE};
    tbl[2] = '{1, 6, 300, RISE};
    tbl[3] = '{0, 13, 270, FALL};
    tbl[4] = '{1, 13, 300, FALL};
    tbl[5] = '{1, 23, 345, FALL};
    tbl[6] = '{1, 24, 348, GROUND};
    tbl[7] = '{0, 25, 336, FALL};
    tbl[8] = '{0, 26, 348, GROUND};
    build_traj(0, 40);
    build_traj(1, 300);

    // Reset
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_dino_y", int'(dy0), 348);
    chk("rst_airborne", int'(air0), 0);
    chk("rst_landed", int'(ld0), 0);
    chk("rst_state", int'(dut.state_q), int'(GROUND));

    // Full jump against trajectory checkpoints
    land_cnt0 = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      wait_nt(tbl[k].cfg, tbl[k].nt);
      if (tbl[k].cfg == 0) begin
        chk("tbl_y", int'(dut.y_int_q), tbl[k].exp_y);
        chk("tbl_state", int'(dut.state_q), int'(tbl[k].exp_st));
      end else begin
        chk("tbl_c_y", int'(dut_c.y_int_q), tbl[k].exp_y);
        chk("tbl_c_state", int'(dut_c.state_q), int'(tbl[k].exp_st));
      end
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("landed_count", land_cnt0, 1);

    // Re-press during RISE is ignored
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_nt(0, 4);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    i = 0;
    while (!ld0 && i < 400) begin
      step(1'b0, 1'b0, 1'b0);
      i++;
    end
    chk("repress_landed_seen", int'(ld0), 1);
    chk("repress_total_ticks", m_nt[0], 26);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    chk("no_buffer", int'(dut.state_q), int'(GROUND));

    // Game over mid-RISE at y=300 (ceiling config)
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    wait_nt(1, 6);
    chk("go_pre_y", int'(dut_c.y_int_q), 300);
    step(1'b0, 1'b1, 1'b0);
    repeat (100) begin
      step(1'b0, 1'b1, 1'b0);
      chk("go_state", int'(dut_c.state_q), int'(DEAD));
      chk("go_y", int'(dut_c.y_int_q), 300);
      chk("go_tcnt", int'(dut_c.u_tick_div.tcnt_q), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("go_exit_state", int'(dut_c.state_q), int'(GROUND));
    repeat (17) step(1'b0, 1'b0, 1'b0);
    chk("go_exit_dino_y", int'(dy1), 348);

    // Press coincident with tick launches on that tick
    wait_tc(PD - 2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("press_tick_state", int'(dut.state_q), int'(RISE));

    // game_over coincident with tick: no position change
    wait_nt(0, 3);
    wait_tc(PD - 2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("go_tick_y", int'(dut.y_int_q), 325);
    chk("go_tick_state", int'(dut.state_q), int'(DEAD));
    repeat (8) step(1'b0, 1'b0, 1'b0);

    // Randomised traffic against the reference model
    rb = 1'b0; rg = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      if (rg) rg = ($urandom_range(0, 9) != 0);
      else    rg = ($urandom_range(0, 299) == 0);
      rr = ($urandom_range(0, 799) == 0);
      step(rb, rg, rr);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dino_jump_ctrl.md
# dino_jump_ctrl

Jump-physics stage for the Dino Run game. It sits directly upstream of the VGA renderer/collision block and consumes the same `controller_report` byte. It turns a jump button press into a vertical trajectory under gravity and drives the dino's `dino_y` into the renderer. `dino_y` is updated only at frame start, so the sprite never tears mid-frame.

## Interface
Parameters:
- `GROUND_Y`, 348: resting y (top of the 32×32 sprite).
- `MIN_Y`, 40: ceiling; y never goes below this value.
- `JUMP_V0`, 12: launch velocity, px/tick; legal range 1..63.
- `GRAVITY`, 1: velocity change per tick; legal range 1..JUMP_V0.
- `PHYS_DIV`, 500_000: clk cycles per physics tick (100 Hz at 50 MHz); must be ≥ 2.
- `JUMP_BIT`, 5: bit of `controller_report` used as the jump button.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `controller_report` in 8: registered controller byte; only `JUMP_BIT` is used.
- `game_over` in 1: level signal from the collision block.
- `frame_start` in 1: one-cycle pulse at vcount==480, hcount==0.
- `dino_y` out 11: sprite y for the renderer.
- `airborne` out 1: high when state ≠ GROUND, sampled like `dino_y`.
- `landed` out 1: one-cycle pulse on the FALL→GROUND transition.

## Operation
- **Edge detect.** `press` = `controller_report[JUMP_BIT]` & ~previous value.
  - `press` in GROUND sets `pending`.
  - `press` in RISE, FALL or DEAD is ignored; there is no jump buffering.
- **Tick divider.** `tcnt` counts 0..PHYS_DIV-1, then wraps.
  - `tick` is asserted in the cycle `tcnt` == PHYS_DIV-1.
  - `tcnt` is held at 0 while in DEAD.
- **Internal state.** `y_int` (11 b), `vel` (6 b unsigned), `state` ∈ {GROUND, RISE, FALL, DEAD}.
- **GROUND**
  - `y_int` = GROUND_Y, `vel` = 0.
  - On `tick` with (`pending` | `press`): `vel` ← JUMP_V0, `y_int` unchanged, `pending` ← 0, go to RISE.
- **RISE**, on `tick`:
  - `y_int` ← max(`y_int` − `vel`, MIN_Y). Compute in 12 b so there is no underflow.
  - If `vel` ≤ GRAVITY: `vel` ← 0, go to FALL (apex). Otherwise `vel` ← `vel` − GRAVITY.
- **FALL**, on `tick`:
  - `nxt` = `y_int` + `vel`.
  - If `nxt` ≥ GROUND_Y: `y_int` ← GROUND_Y, `vel` ← 0, go to GROUND, pulse `landed`.
  - Otherwise `y_int` ← `nxt` and `vel` ← min(`vel` + GRAVITY, JUMP_V0).
- **DEAD**
  - Any state goes to DEAD on the cycle after `game_over`=1.
  - `y_int` and `vel` freeze; `pending` is cleared.
  - When `game_over` returns to 0: `y_int` ← GROUND_Y, `vel` ← 0, go to GROUND.
- **Output register.** On `frame_start`: `dino_y` ← `y_int`, `airborne` ← (`state` ≠ GROUND). Both hold between pulses.

## Timing
- **Reset values:** `dino_y`=GROUND_Y, `airborne`=0, `landed`=0, `state`=GROUND, `y_int`=GROUND_Y, `vel`=0, `tcnt`=0, `pending`=0, previous-button register=0.
- **Reset mid-jump** returns to the reset values at the next clock edge. No partial trajectory survives reset.
- **Latency:**
  - `press` → launch at the next `tick`.
  - Internal state → `dino_y` at the next `frame_start`.
  - `landed` is asserted in the cycle after the landing `tick`.
- **Trajectory length.** With the default parameters, one jump is 26 ticks from launch to GROUND:
  - 1 launch tick;
  - 12 RISE ticks, apex `y_int`=270;
  - 13 FALL ticks.
- **Simultaneous events:**
  - `game_over` with `tick` in the same cycle: `game_over` wins and no physics update occurs.
  - `press` with `tick` in GROUND in the same cycle: launch on that tick.
  - `frame_start` with a state update in the same cycle: `dino_y` takes the pre-update `y_int`.
- **Ceiling.** If MIN_Y clamps during RISE, the rise continues until `vel` reaches the apex condition while `y_int` stays at MIN_Y.

## Structure
- **Package `dino_pkg`** holds:
  - typedef `dino_jump_state_t` (GROUND, RISE, FALL, DEAD);
  - constants `DINO_GROUND_Y`=348, `DINO_W`=32, `DINO_H`=32, `CTRL_JUMP_BIT`=5, `CTRL_REPLAY_BIT`=4.
  - The renderer imports the same package.
- **Sub-module `dino_tick_div`** (parameter PHYS_DIV; ports `clk`, `reset`, `hold`, `tick`). It is the only natural split.
- **Everything else stays in one FSM module:** edge detect, FSM and output register.

## Test plan
Bench parameters: PHYS_DIV=4, `frame_start` every 16 cycles.
- **Reset.** Reset for 3 cycles → `dino_y`=348, `airborne`=0, `landed`=0, `state`=GROUND.
- **Full jump.** One press in GROUND → launch at the next tick.
  - After 13 ticks: `y_int`=270, state FALL.
  - After 26 ticks: GROUND with `y_int`=348 and exactly one `landed` pulse.
  - `dino_y` changes only in cycles following `frame_start`.
- **Re-press while airborne.** Press again during RISE → ignored; the trajectory is identical and the total is still 26 ticks.
- **Game over mid-jump.**
  - Assert `game_over` mid-RISE with `y_int`=300 → state DEAD, `y_int` stays 300 for 100 cycles, `tcnt` stays 0.
  - Deassert → GROUND, and `dino_y`=348 after the next `frame_start`.
- **Coincident events.**
  - `press` and `tick` in the same cycle → launch on that tick.
  - `game_over` and `tick` in the same cycle → no position change.
- **Ceiling clamp.** MIN_Y=300, JUMP_V0=12 → `y_int` never goes below 300; apex after 12 RISE ticks; landing still occurs at 348.
